// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU.
//   Single-cycle ops (add, and, not, pass, sll, srl, sra and the illegal
//   codes 10..15) finish one cycle after acceptance.
//   Iterative ops (mul, divu, remu) spend WIDTH cycles in CALC, handling
//   one operand bit per cycle. They finish WIDTH+1 cycles after acceptance.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. busy stays high from the next cycle up to and including the
// done cycle. done is a one-cycle pulse. result and div_by_zero are valid
// with done and hold their value until the next done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only while busy=0
//   aluop[3:0]          operation code
//   a, b [WIDTH-1:0]    operands, captured when a request is accepted
//   busy, done          status (registered)
//   result[WIDTH-1:0]   result of the last completed operation
//   div_by_zero         divu/remu completed with b=0
//   dbg_state[1:0]      current FSM state (0 IDLE, 1 CALC, 2 FIN)
module alu_iter #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       aluop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_PASS = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_DIVU = 4'd8;
   localparam logic [3:0] OP_REMU = 4'd9;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [3:0]       op;
   // The meaning of these registers depends on the operation:
   //   mul : acc = partial product, opa = multiplicand shifted left,
   //         opb = multiplier shifted right
   //   div : acc = partial remainder, opa = dividend shifting out at the
   //         top while quotient bits shift in at the bottom,
   //         opb = divisor (held constant)
   logic [WIDTH-1:0] acc, opa, opb;
   logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt;
   logic [WIDTH-1:0] quick;
   logic             is_iter;
   logic [WIDTH:0]   sh_rem, trial;

   assign dbg_state = state;
   assign is_iter   = (aluop == OP_MUL) || (aluop == OP_DIVU) || (aluop == OP_REMU);

   // Restoring division step. A borrow in trial[WIDTH] means the divisor
   // does not fit. When b=0 the divisor always fits, so the quotient
   // becomes all-ones and the remainder ends up equal to a. That is
   // exactly the divide-by-zero result, so no special-case path is needed.
   assign sh_rem = {acc, opa[WIDTH-1]};
   assign trial  = sh_rem - {1'b0, opb};

   always_comb begin
      quick = '0;
      case (aluop)
         OP_ADD:  quick = a + b;
         OP_AND:  quick = a & b;
         OP_NOT:  quick = ~a;
         OP_PASS: quick = a;
         OP_SLL:  quick = a << b[SHW-1:0];
         OP_SRL:  quick = a >> b[SHW-1:0];
         OP_SRA:  quick = $unsigned($signed(a) >>> b[SHW-1:0]);
         default: quick = '0;
      endcase
   end

   always_comb begin
      acc_nxt = acc;
      opa_nxt = opa;
      opb_nxt = opb;
      if (op == OP_MUL) begin
         acc_nxt = acc + (opb[0] ? opa : '0);
         opa_nxt = opa << 1;
         opb_nxt = opb >> 1;
      end else begin
         acc_nxt = trial[WIDTH] ? sh_rem[WIDTH-1:0] : trial[WIDTH-1:0];
         opa_nxt = {opa[WIDTH-2:0], ~trial[WIDTH]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         op          <= '0;
         acc         <= '0;
         opa         <= '0;
         opb         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op   <= aluop;
                  cnt  <= '0;
                  busy <= 1'b1;
                  if (is_iter) begin
                     acc   <= '0;
                     opa   <= a;
                     opb   <= b;
                     state <= CALC;
                  end else begin
                     result      <= quick;
                     div_by_zero <= 1'b0;
                     done        <= 1'b1;
                     state       <= FIN;
                  end
               end
            end
            CALC: begin
               acc <= acc_nxt;
               opa <= opa_nxt;
               opb <= opb_nxt;
               if (cnt == CNT_LAST) begin
                  // Last step. Take the result from the next-state values.
                  result      <= (op == OP_DIVU) ? opa_nxt : acc_nxt;
                  div_by_zero <= (op != OP_MUL) && (opb == '0);
                  done        <= 1'b1;
                  state       <= FIN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter. One instance is built at WIDTH=16 and one at
// WIDTH=32. Both share the operand and opcode inputs, and each has its
// own start. Expected values come from a plain-arithmetic model.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start16, start32;
   logic [3:0]  aluop;
   logic [31:0] a, b;

   logic        busy16, done16, dbz16;
   logic [15:0] result16;
   logic [1:0]  st16;
   logic        busy32, done32, dbz32;
   logic [31:0] result32;
   logic [1:0]  st32;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_iter #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .aluop(aluop),
      .a(a[15:0]), .b(b[15:0]), .busy(busy16), .done(done16),
      .result(result16), .div_by_zero(dbz16), .dbg_state(st16)
   );

   alu_iter #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .aluop(aluop),
      .a(a), .b(b), .busy(busy32), .done(done32),
      .result(result32), .div_by_zero(dbz32), .dbg_state(st32)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model. Returns {div_by_zero, result} for width w (16 or 32).
   function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] av,
                                         input logic [31:0] bv, input int w);
      logic [63:0] m, x, y, r;
      int sh;
      logic z;
      m  = (64'd1 << w) - 64'd1;
      x  = {32'd0, av} & m;
      y  = {32'd0, bv} & m;
      sh = int'(y % 64'(w));
      z  = 1'b0;
      case (op)
         4'd0: r = (x + y) & m;
         4'd1: r = x & y;
         4'd2: r = ~x & m;
         4'd3: r = x;
         4'd4: r = (x << sh) & m;
         4'd5: r = x >> sh;
         4'd6: begin
            r = x >> sh;
            if (x[w-1]) r = r | (m & ~(m >> sh));
         end
         4'd7: r = (x * y) & m;
         4'd8: begin r = (y == 0) ? m : x / y; z = (y == 0); end
         4'd9: begin r = (y == 0) ? x : x % y; z = (y == 0); end
         default: r = 64'd0;
      endcase
      return {z, r[31:0]};
   endfunction

   // Issue one op to both instances. While each one is busy, and also in
   // its done cycle, the bench scrambles start, aluop, a and b. None of
   // that may change the result or start a new request.
   task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input string tag);
      logic [32:0] e16, e32;
      int exp_lat16, exp_lat32, lat;
      bit fin16, fin32, post16, post32;
      e16 = model(op, av, bv, 16);
      e32 = model(op, av, bv, 32);
      exp_lat16 = (op >= 4'd7 && op <= 4'd9) ? 17 : 1;
      exp_lat32 = (op >= 4'd7 && op <= 4'd9) ? 33 : 1;
      fin16 = 0; fin32 = 0; post16 = 0; post32 = 0; lat = 0;
      @(negedge clk);
      aluop = op; a = av; b = bv; start16 = 1'b1; start32 = 1'b1;
      while (!(post16 && post32) && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (!fin16) begin
            if (done16) begin
               fin16 = 1;
               chk({tag, "/lat16"}, 64'(lat), 64'(exp_lat16));
               chk({tag, "/res16"}, 64'(result16), 64'(e16[15:0]));
               chk({tag, "/dbz16"}, 64'(dbz16), 64'(e16[32]));
               chk({tag, "/busy16_done"}, 64'(busy16), 64'd1);
            end else if (lat <= exp_lat16) begin
               chk({tag, "/busy16"}, 64'(busy16), 64'd1);
            end
         end else if (!post16) begin
            post16 = 1;
            chk({tag, "/done16_once"}, 64'(done16), 64'd0);
            chk({tag, "/idle16"}, 64'(busy16), 64'd0);
            chk({tag, "/hold16"}, 64'(result16), 64'(e16[15:0]));
         end
         if (!fin32) begin
            if (done32) begin
               fin32 = 1;
               chk({tag, "/lat32"}, 64'(lat), 64'(exp_lat32));
               chk({tag, "/res32"}, 64'(result32), 64'(e32[31:0]));
               chk({tag, "/dbz32"}, 64'(dbz32), 64'(e32[32]));
            end else if (lat <= exp_lat32) begin
               chk({tag, "/busy32"}, 64'(busy32), 64'd1);
            end
         end else if (!post32) begin
            post32 = 1;
            chk({tag, "/done32_once"}, 64'(done32), 64'd0);
            chk({tag, "/idle32"}, 64'(busy32), 64'd0);
            chk({tag, "/hold32"}, 64'(result32), 64'(e32[31:0]));
         end
         start16 = (!post16 && (!fin16 || done16)) ? 1'($urandom_range(0, 1)) : 1'b0;
         start32 = (!post32 && (!fin32 || done32)) ? 1'($urandom_range(0, 1)) : 1'b0;
         aluop   = 4'($urandom_range(0, 15));
         a       = $urandom;
         b       = $urandom;
      end
      start16 = 1'b0;
      start32 = 1'b0;
      if (!post16) chk({tag, "/timeout16"}, 64'd0, 64'd1);
      if (!post32) chk({tag, "/timeout32"}, 64'd0, 64'd1);
   endtask

   initial begin
      bit seen_done;
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      // Reset state.
      rst_n = 1'b0; start16 = 1'b0; start32 = 1'b0; aluop = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst/busy16", 64'(busy16), 64'd0);
      chk("rst/done16", 64'(done16), 64'd0);
      chk("rst/res16", 64'(result16), 64'd0);
      chk("rst/dbz16", 64'(dbz16), 64'd0);
      chk("rst/state16", 64'(st16), 64'd0);
      chk("rst/res32", 64'(result32), 64'd0);
      chk("rst/busy32", 64'(busy32), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases.
      run_op(4'd0, 32'h0000_FFFF, 32'h0000_0001, "add_wrap");
      run_op(4'd6, 32'h0000_8000, 32'h0000_000F, "sra15");
      run_op(4'd5, 32'h0000_8000, 32'h0000_000F, "srl15");
      run_op(4'd4, 32'h0000_8000, 32'h0000_0010, "sll_amt0_16");
      run_op(4'd7, 32'h0000_0123, 32'h0000_0100, "mul");
      run_op(4'd8, 32'd100, 32'd7, "divu");
      run_op(4'd9, 32'd100, 32'd7, "remu");
      run_op(4'd8, 32'h0000_1234, 32'd0, "divu_b0");
      run_op(4'd9, 32'h0000_1234, 32'd0, "remu_b0");
      run_op(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, "illegal");
      run_op(4'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
      run_op(4'd2, 32'h0000_00FF, 32'h0, "not");
      run_op(4'd3, 32'hCAFE_F00D, 32'h0, "pass");

      // Reset in the middle of a divide.
      @(negedge clk);
      aluop = 4'd8; a = 32'd5000; b = 32'd3; start16 = 1'b1; start32 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; start32 = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst/busy16", 64'(busy16), 64'd0);
      chk("midrst/done16", 64'(done16), 64'd0);
      chk("midrst/res16", 64'(result16), 64'd0);
      chk("midrst/state16", 64'(st16), 64'd0);
      chk("midrst/busy32", 64'(busy32), 64'd0);
      chk("midrst/res32", 64'(result32), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done16 || done32 || busy16 || busy32) seen_done = 1;
      end
      chk("midrst/no_done", 64'(seen_done), 64'd0);
      run_op(4'd0, 32'd40, 32'd2, "add_after_rst");

      // Random operations.
      for (int i = 0; i < 50; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         else if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000_00FF;
         run_op(rop, ra, rb, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, giving operand/result width (legal: 8..64, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the number of operand-B bits used as shift amount.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 aluop  input  4  operation code (encoding per REQ-010).
REQ-007 a, b  input  WIDTH each  operands; captured at accepted start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done is pulsed, inclusive.
REQ-009 done  output  1  one-cycle pulse, result valid; result  output  WIDTH; div_by_zero  output  1 (valid with done).

Function
REQ-010 Encodings SHALL be: 0 add, 1 and, 2 not (~a), 3 pass (a), 4 sll, 5 srl, 6 sra, 7 mul, 8 divu, 9 remu; 10..15 illegal.
REQ-011 add SHALL be two's-complement modulo 2^WIDTH; carry discarded.
REQ-012 sll/srl/sra SHALL shift a by b[SHW-1:0]; sra replicates a[WIDTH-1]; shift of 0 returns a.
REQ-013 mul SHALL return the low WIDTH bits of the unsigned product a*b (equal to signed low half).
REQ-014 divu/remu SHALL return unsigned quotient/remainder of a/b by restoring division, one quotient bit per cycle.
REQ-015 b=0 for divu/remu SHALL give quotient all-ones, remainder = a, div_by_zero=1; div_by_zero SHALL be 0 for every other completion.
REQ-016 Illegal opcodes SHALL complete as single-cycle ops with result 0.
REQ-017 A start is accepted only when start=1 and busy=0; start while busy=1 SHALL be ignored (no queueing).
REQ-018 FSM states SHALL be IDLE, CALC, FIN: IDLE->FIN on accepted single-cycle op; IDLE->CALC on accepted mul/divu/remu; CALC->FIN when iteration counter reaches WIDTH-1; FIN->IDLE unconditionally.
REQ-019 Single-cycle op accepted in cycle T SHALL raise done in cycle T+1 (busy high in T+1 only).
REQ-020 mul/divu/remu accepted in cycle T SHALL raise done in cycle T+WIDTH+1, independent of operand values including b=0.
REQ-021 Iteration counter SHALL be $clog2(WIDTH) bits, cleared on accept, never wrapping while in CALC.
REQ-022 Operands SHALL be held in internal registers; changes on a/b/aluop after accept SHALL not affect the result.
REQ-023 result and div_by_zero SHALL hold their last completion value until the next done; done SHALL never be high two consecutive cycles.
REQ-024 start in the FIN cycle SHALL be ignored; a new start is accepted earliest in the cycle after done.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, div_by_zero=0, counter=0.
REQ-026 Reset during CALC or FIN SHALL abort the operation with no done pulse; first start after rst_n deasserts is accepted normally.

Verification
REQ-027 WIDTH=16: start add a=16'hFFFF b=16'h0001 in cycle T -> done at T+1, result 16'h0000, busy high only T+1.
REQ-028 WIDTH=16: sra a=16'h8000 b=16'h000F -> result 16'hFFFF; srl same -> 16'h0001; sll b=16'h0010 (amount 0) -> 16'h8000.
REQ-029 WIDTH=16: mul a=16'h0123 b=16'h0100 at T -> done exactly T+17, result 16'h2300; start pulses during T+1..T+17 ignored.
REQ-030 WIDTH=16: divu a=100 b=7 -> result 14; remu -> 2; divu b=0 a=16'h1234 -> 16'hFFFF, div_by_zero=1, done at T+17.
REQ-031 Assert rst_n=0 mid-divu at T+5 -> busy/done/result 0 same cycle, no done afterwards; next add completes at accept+1.
REQ-032 WIDTH=32 rerun of REQ-029/030 -> latency 33 cycles, same numeric results zero-extended.
